// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and constants for the hazard match pipeline.
//   regaddr_t : register-file address (4 bits by default)
//   PC_REG    : address of the program counter; never a forwarding source
//   ctrl_t    : decode-stage control bundle carried into the E stage
//   sat_inc16 : saturating 16-bit increment used by the perf counters
package hazard_pkg;

    localparam int unsigned REG_AW_DEF = 4;

    typedef logic [REG_AW_DEF-1:0] regaddr_t;

    localparam regaddr_t PC_REG = 4'hF;

    typedef struct packed {
        logic RegWrite;
        logic MemtoReg;
        logic PCSrc;
        logic Branch;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hazard_match_pipe_stage_reg.sv
// pipe_stage_reg
//   Generic pipeline stage register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the stage
//   i_clr : synchronous clear (bubble insertion), wins over i_d
//   i_d   : next-stage data
//   o_q   : registered data
module pipe_stage_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_match_pipe.sv
// hazard_match_pipe
//   E/M/W pipeline registers for register addresses and control bits, plus the
//   address comparators feeding a hazard unit.
//   Inputs : clk, rst (async active-low), RA1D/RA2D/WA3D, RegWriteD,
//            MemtoRegD, PCSrcD, BranchD, CondExE, FlushE, StallD, FlushD
//   Outputs: PCSrcE/M/W, MemtoRegE, RegWriteM/W, BranchTakenE,
//            Match_1E_M, Match_2E_M, Match_1E_W, Match_2E_W, Match_12D_E
//   Option : HAZARD_PERF_EN adds StallCnt[15:0] and FlushCnt[15:0]
//            (saturating event counters, cleared by rst).
module hazard_match_pipe
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] WA3D,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              PCSrcD,
    input  logic              BranchD,
    input  logic              CondExE,
    input  logic              FlushE,
    input  logic              StallD,
    input  logic              FlushD,
    output logic              PCSrcE,
    output logic              PCSrcM,
    output logic              PCSrcW,
    output logic              MemtoRegE,
    output logic              RegWriteM,
    output logic              RegWriteW,
    output logic              BranchTakenE,
    output logic              Match_1E_M,
    output logic              Match_2E_M,
    output logic              Match_1E_W,
    output logic              Match_2E_W,
    output logic              Match_12D_E
`ifdef HAZARD_PERF_EN
   ,output logic [15:0]       StallCnt,
    output logic [15:0]       FlushCnt
`endif
);

    localparam int unsigned EW = 3 * REG_AW + CTRL_W;
    localparam int unsigned MW = REG_AW + 2;

    logic [REG_AW-1:0] w_pc;
    assign w_pc = REG_AW'(PC_REG);

    // E stage
    ctrl_t             w_ctrl_d;
    ctrl_t             w_ctrl_e;
    logic [EW-1:0]     w_e_d;
    logic [EW-1:0]     w_e_q;
    logic [REG_AW-1:0] w_ra1e;
    logic [REG_AW-1:0] w_ra2e;
    logic [REG_AW-1:0] w_wa3e;

    assign w_ctrl_d = '{RegWrite: RegWriteD, MemtoReg: MemtoRegD,
                        PCSrc: PCSrcD, Branch: BranchD};
    assign w_e_d    = {RA1D, RA2D, WA3D, w_ctrl_d};

    pipe_stage_reg #(.W(EW)) u_stage_e (
        .clk   (clk),
        .rst_n (rst),
        .i_clr (FlushE),
        .i_d   (w_e_d),
        .o_q   (w_e_q)
    );

    assign {w_ra1e, w_ra2e, w_wa3e, w_ctrl_e} = w_e_q;

    // M stage: writes and PC updates survive only if the condition passed
    logic [MW-1:0]     w_m_d;
    logic [MW-1:0]     w_m_q;
    logic [REG_AW-1:0] w_wa3m;
    logic              w_regwrite_m;
    logic              w_pcsrc_m;

    assign w_m_d = {w_wa3e, w_ctrl_e.RegWrite & CondExE, w_ctrl_e.PCSrc & CondExE};

    pipe_stage_reg #(.W(MW)) u_stage_m (
        .clk   (clk),
        .rst_n (rst),
        .i_clr (1'b0),
        .i_d   (w_m_d),
        .o_q   (w_m_q)
    );

    assign {w_wa3m, w_regwrite_m, w_pcsrc_m} = w_m_q;

    // W stage
    logic [MW-1:0]     w_w_q;
    logic [REG_AW-1:0] w_wa3w;
    logic              w_regwrite_w;
    logic              w_pcsrc_w;

    pipe_stage_reg #(.W(MW)) u_stage_w (
        .clk   (clk),
        .rst_n (rst),
        .i_clr (1'b0),
        .i_d   (w_m_q),
        .o_q   (w_w_q)
    );

    assign {w_wa3w, w_regwrite_w, w_pcsrc_w} = w_w_q;

    // Stage occupancy since reset: [2]=E, [1]=M, [0]=W. A stage emptied by
    // reset holds all-zero addresses that would otherwise compare equal to
    // register 0; bubbles from FlushE still count as occupied.
    logic [2:0] w_occ_d;
    logic [2:0] w_occ_q;

    assign w_occ_d = {1'b1, w_occ_q[2:1]};

    pipe_stage_reg #(.W(3)) u_stage_occ (
        .clk   (clk),
        .rst_n (rst),
        .i_clr (1'b0),
        .i_d   (w_occ_d),
        .o_q   (w_occ_q)
    );

    // Comparators; a destination of PC never matches
    logic w_e_live;
    logic w_m_live;
    logic w_w_live;

    assign w_e_live = w_occ_q[2] && (w_wa3e != w_pc);
    assign w_m_live = w_occ_q[2] && w_occ_q[1] && (w_wa3m != w_pc);
    assign w_w_live = w_occ_q[2] && w_occ_q[0] && (w_wa3w != w_pc);

    assign Match_1E_M  = w_m_live && (w_ra1e == w_wa3m);
    assign Match_2E_M  = w_m_live && (w_ra2e == w_wa3m);
    assign Match_1E_W  = w_w_live && (w_ra1e == w_wa3w);
    assign Match_2E_W  = w_w_live && (w_ra2e == w_wa3w);
    assign Match_12D_E = w_e_live && ((RA1D == w_wa3e) || (RA2D == w_wa3e));

    assign PCSrcE       = w_ctrl_e.PCSrc;
    assign MemtoRegE    = w_ctrl_e.MemtoReg;
    assign BranchTakenE = w_ctrl_e.Branch & CondExE;
    assign PCSrcM       = w_pcsrc_m;
    assign RegWriteM    = w_regwrite_m;
    assign PCSrcW       = w_pcsrc_w;
    assign RegWriteW    = w_regwrite_w;

`ifdef HAZARD_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallD) begin
                r_stall_cnt <= sat_inc16(r_stall_cnt);
            end
            if (FlushD || FlushE) begin
                r_flush_cnt <= sat_inc16(r_flush_cnt);
            end
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`else
    // StallD/FlushD only feed the perf counters
    logic w_unused_perf;
    assign w_unused_perf = StallD ^ FlushD;
`endif

endmodule

// File: doc/hazard_match_pipe.md
HAZARD_MATCH_PIPE -- requirements
Module: hazard_match_pipe

Interface
REQ-001 SHALL have parameter: REG_AW, 4, register-address width.
REQ-002 SHALL have port: clk  input  1  single clock; all flops rise-edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: RA1D, RA2D, WA3D  input  REG_AW  decode-stage source and destination addresses.
REQ-005 SHALL have ports: RegWriteD, MemtoRegD, PCSrcD, BranchD  input  1  decode-stage control bits.
REQ-006 SHALL have port: CondExE  input  1  execute-stage condition passed.
REQ-007 SHALL have ports: FlushE, StallD, FlushD  input  1  from the hazard unit.
REQ-008 SHALL have ports: PCSrcE, PCSrcM, PCSrcW, MemtoRegE, RegWriteM, RegWriteW, BranchTakenE  output  1  pipelined or derived control.
REQ-009 SHALL have ports: Match_1E_M, Match_2E_M, Match_1E_W, Match_2E_W, Match_12D_E  output  1  address-compare results.

Function
REQ-010 SHALL register D->E each clk: RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, PCSrcE, BranchE.
REQ-011 SHALL, when FlushE=1 at an edge, load zero into all E-stage control bits and addresses; FlushE has priority over new D data.
REQ-012 SHALL register E->M: WA3M <= WA3E; RegWriteM <= RegWriteE & CondExE; PCSrcM <= PCSrcE & CondExE.
REQ-013 SHALL register M->W: WA3W, RegWriteW, PCSrcW from M-stage values, unconditionally.
REQ-014 SHALL drive BranchTakenE = BranchE & CondExE combinationally, zero latency.
REQ-015 SHALL drive Match_1E_M = (RA1E == WA3M), Match_2E_M = (RA2E == WA3M), Match_1E_W = (RA1E == WA3W), Match_2E_W = (RA2E == WA3W), all combinational.
REQ-016 SHALL drive Match_12D_E = (RA1D == WA3E) | (RA2D == WA3E), combinational.
REQ-017 SHALL force every Match output to 0 when the compared destination equals 4'hF (PC is never forwarded).
REQ-018 SHALL NOT gate Match outputs with RegWrite; qualification is done by the hazard unit.
REQ-019 SHALL propagate a flushed (bubble) E stage as RegWrite=0, PCSrc=0 through M and W on the two following edges.
REQ-020 SHALL treat StallD as having no effect on D->E loading; the D register upstream holds, and E is bubbled via FlushE.

Reset
REQ-021 SHALL, while rst=0, clear all E/M/W addresses and control bits to 0 asynchronously, so all outputs read 0.
REQ-022 SHALL, on a rst assertion mid-pipeline, discard every in-flight instruction; first valid E data appears at the first edge after rst deasserts.

Configuration
REQ-023 SHALL, when HAZARD_PERF_EN is defined, add outputs StallCnt[15:0] and FlushCnt[15:0].
REQ-024 With HAZARD_PERF_EN, StallCnt SHALL increment on each edge with StallD=1, and FlushCnt on each edge with FlushD|FlushE=1, both saturating at 16'hFFFF and cleared by rst.
REQ-025 SHALL, when HAZARD_PERF_EN is undefined, omit both ports and counters entirely.

Structure
REQ-026 SHALL take from shared package hazard_pkg: regaddr_t (REG_AW-bit), PC_REG = 4'hF, and struct ctrl_t {RegWrite, MemtoReg, PCSrc, Branch}.
REQ-027 SHALL build each stage from one sub-module pipe_stage_reg (parameterised width, async active-low reset, synchronous clear).

Verification
REQ-028 SHALL be shown: after reset release, all outputs = 0 and no Match asserted, including the WA3=0/RA=0 case.
REQ-029 SHALL be shown: D{WA3D=3, RegWriteD=1} then D{RA1D=3}; one edge later Match_1E_M=1, the next edge Match_1E_W=1.
REQ-030 SHALL be shown: LDR D{WA3D=5, MemtoRegD=1} followed by RA2D=5; Match_12D_E=1 and MemtoRegE=1 in the same cycle; FlushE=1 puts a bubble in E (MemtoRegE=0 next cycle).
REQ-031 SHALL be shown: BranchD=1, CondExE=0; BranchTakenE=0 and PCSrcM=0; repeat with CondExE=1, giving BranchTakenE=1 and PCSrcM=1, then PCSrcW=1.
REQ-032 SHALL be shown: WA3D=15 with RA1D=15; no Match output asserts in any stage.
REQ-033 SHALL be shown, with HAZARD_PERF_EN: 70000 cycles of StallD=1 give StallCnt=16'hFFFF held; an rst pulse returns it to 0.
